// File: rtl/traffic_pkg.sv
// Shared traffic-light encoding and the per-head legal-transition rule,
// used by the monitor and its per-head trackers.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    LEFT   = 2'd3
  } traffic_light;

  // Holding any aspect is always legal; otherwise only the listed sequence steps are.
  function automatic logic legal_transition(input traffic_light from, input traffic_light to);
    logic ok;
    ok = 1'b0;
    if (from == to) begin
      ok = 1'b1;
    end else begin
      unique case (from)
        GREEN:   ok = (to == YELLOW) || (to == LEFT);
        LEFT:    ok = (to == YELLOW);
        YELLOW:  ok = (to == RED);
        RED:     ok = (to == GREEN) || (to == LEFT);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/light_monitor_if.sv
// Observed signal heads plus error flags of the light monitor; err_count and
// its width parameter exist only when LIGHT_MON_COUNT_EN is defined.
interface light_monitor_if
`ifdef LIGHT_MON_COUNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  import traffic_pkg::*;

  traffic_light north;
  traffic_light south;
  traffic_light east;
  traffic_light west;
  logic         err_conflict;
  logic         err_pair;
  logic         err_seq;
  logic         err_yellow;
  logic         err_sticky;

`ifdef LIGHT_MON_COUNT_EN
  logic [CNT_W-1:0] err_count;

  modport master (output north, south, east, west,
                  input  err_conflict, err_pair, err_seq, err_yellow, err_sticky, err_count);
  modport slave  (input  north, south, east, west,
                  output err_conflict, err_pair, err_seq, err_yellow, err_sticky, err_count);
`else
  modport master (output north, south, east, west,
                  input  err_conflict, err_pair, err_seq, err_yellow, err_sticky);
  modport slave  (input  north, south, east, west,
                  output err_conflict, err_pair, err_seq, err_yellow, err_sticky);
`endif

endinterface

// File: rtl/light_tracker.sv
// Per-head tracker: remembers the previous aspect and times YELLOW intervals,
// flagging illegal transitions and too-short/too-long YELLOW (combinational, pre-register).
module light_tracker
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 3,
  parameter int YELLOW_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  traffic_light head,
  output logic         seq_err,
  output logic         yellow_err
);

  localparam int            YW   = $clog2(YELLOW_MAX + 2);
  localparam logic [YW-1:0] YSAT = YW'(YELLOW_MAX + 1);
  localparam logic [YW-1:0] YMIN = YW'(YELLOW_MIN);

  traffic_light  prev_q, prev_d;
  logic          valid_q, valid_d;
  logic [YW-1:0] ycnt_q, ycnt_d;

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    prev_d     = head;
    valid_d    = 1'b1;
    ycnt_d     = '0;
    seq_err    = 1'b0;
    yellow_err = 1'b0;
    if (valid_q) begin
      seq_err = !legal_transition(prev_q, head);
      if (head == YELLOW) begin
        // A zero count while YELLOW holds marks an interval begun before tracking started.
        if (prev_q != YELLOW)                      ycnt_d = YW'(1);
        else if (ycnt_q == '0 || ycnt_q == YSAT)   ycnt_d = ycnt_q;
        else                                       ycnt_d = ycnt_q + 1'b1;
        yellow_err = (ycnt_d == YSAT) && (ycnt_q != YSAT);
      end else if (prev_q == YELLOW && ycnt_q != '0 && ycnt_q < YMIN) begin
        yellow_err = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= RED;
      valid_q <= 1'b0;
      ycnt_q  <= '0;
    end else begin
      prev_q  <= prev_d;
      valid_q <= valid_d;
      ycnt_q  <= ycnt_d;
    end
  end

endmodule

// File: rtl/light_monitor.sv
// Intersection light monitor: conflict and pairing checks plus four head trackers.
// Defining LIGHT_MON_COUNT_EN adds the saturating err_count register.
module light_monitor
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 3,
  parameter int YELLOW_MAX = 8,
  parameter int CNT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  light_monitor_if.slave  bus
);

  if (YELLOW_MIN < 1 || YELLOW_MAX < YELLOW_MIN || CNT_W < 1) begin : g_bad_params
    $error("light_monitor: illegal parameter combination");
  end

  logic [3:0] seq_err;
  logic [3:0] yellow_err;

  light_tracker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_north (
    .clk(clk), .rst(rst), .head(bus.north), .seq_err(seq_err[0]), .yellow_err(yellow_err[0]));
  light_tracker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_south (
    .clk(clk), .rst(rst), .head(bus.south), .seq_err(seq_err[1]), .yellow_err(yellow_err[1]));
  light_tracker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_east (
    .clk(clk), .rst(rst), .head(bus.east), .seq_err(seq_err[2]), .yellow_err(yellow_err[2]));
  light_tracker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_west (
    .clk(clk), .rst(rst), .head(bus.west), .seq_err(seq_err[3]), .yellow_err(yellow_err[3]));

  logic conflict_q, conflict_d;
  logic pair_q, pair_d;
  logic seq_q, seq_d;
  logic yellow_q, yellow_d;
  logic sticky_q, sticky_d;
  logic any_d;

  // Sticky is fed from the same next-state terms so it rises with the first pulse.
  always_comb begin
    conflict_d = ((bus.north != RED) || (bus.south != RED)) &&
                 ((bus.east  != RED) || (bus.west  != RED));
    pair_d     = (bus.north != bus.south) || (bus.east != bus.west);
    seq_d      = |seq_err;
    yellow_d   = |yellow_err;
    any_d      = conflict_d | pair_d | seq_d | yellow_d;
    sticky_d   = sticky_q | any_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
      pair_q     <= 1'b0;
      seq_q      <= 1'b0;
      yellow_q   <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      pair_q     <= pair_d;
      seq_q      <= seq_d;
      yellow_q   <= yellow_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.err_conflict = conflict_q;
  assign bus.err_pair     = pair_q;
  assign bus.err_seq      = seq_q;
  assign bus.err_yellow   = yellow_q;
  assign bus.err_sticky   = sticky_q;

`ifdef LIGHT_MON_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (any_d && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.err_count = count_q;
`endif

endmodule

// File: tb/tb_light_monitor.sv
// Scoreboard bench for light_monitor (YELLOW_MIN=3, YELLOW_MAX=5): the driver queues
// hand-computed flags per sample, a monitor compares them one cycle later.
module tb_light_monitor;
  import traffic_pkg::*;

  localparam int YMIN = 3;
  localparam int YMAX = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

`ifdef LIGHT_MON_COUNT_EN
  light_monitor_if #(.CNT_W(8)) bus ();
`else
  light_monitor_if bus ();
`endif

  light_monitor #(.YELLOW_MIN(YMIN), .YELLOW_MAX(YMAX), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       conflict;
    logic       pair;
    logic       seq;
    logic       yellow;
    logic       sticky;
    logic [7:0] count;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic       m_sticky    = 1'b0;
  logic [7:0] m_count     = 8'd0;

  task automatic apply(input string name, input logic r,
                       input traffic_light n, input traffic_light s,
                       input traffic_light e, input traffic_light w,
                       input logic ec, input logic ep, input logic es, input logic ey);
    exp_t x;
    @(negedge clk);
    rst       = r;
    bus.north = n;
    bus.south = s;
    bus.east  = e;
    bus.west  = w;
    if (r) begin
      {ec, ep, es, ey} = 4'b0000;
      m_sticky = 1'b0;
      m_count  = 8'd0;
    end else if (ec | ep | es | ey) begin
      m_sticky = 1'b1;
      if (m_count != 8'hFF) m_count = m_count + 8'd1;
    end
    x.name     = name;
    x.conflict = ec;
    x.pair     = ep;
    x.seq      = es;
    x.yellow   = ey;
    x.sticky   = m_sticky;
    x.count    = m_count;
    sb_q.push_back(x);
  endtask

  task automatic ns_ew(input string name, input traffic_light ns, input traffic_light ew,
                       input logic ec, input logic ep, input logic es, input logic ey);
    apply(name, 1'b0, ns, ns, ew, ew, ec, ep, es, ey);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) apply("reset", 1'b1, RED, RED, RED, RED, 0, 0, 0, 0);
  endtask

  task automatic check(input exp_t want, input logic c, input logic p, input logic s,
                       input logic y, input logic st, input logic [7:0] cnt);
    logic ok;
    vectors++;
    ok = (c === want.conflict) && (p === want.pair) && (s === want.seq) &&
         (y === want.yellow) && (st === want.sticky);
`ifdef LIGHT_MON_COUNT_EN
    ok = ok && (cnt === want.count);
`endif
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got conf=%b pair=%b seq=%b yel=%b sticky=%b cnt=%0d, want conf=%b pair=%b seq=%b yel=%b sticky=%b cnt=%0d",
               want.name, c, p, s, y, st, cnt,
               want.conflict, want.pair, want.seq, want.yellow, want.sticky, want.count);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per clock.
  initial begin
    exp_t       want;
    logic [7:0] cnt;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        want = sb_q.pop_front();
`ifdef LIGHT_MON_COUNT_EN
        cnt = bus.err_count;
`else
        cnt = want.count;
`endif
        check(want, bus.err_conflict, bus.err_pair, bus.err_seq, bus.err_yellow,
              bus.err_sticky, cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Legal full cycle: no flag ever.
    do_reset(3);
    for (int i = 0; i < 10; i++) ns_ew("legal_ns_green", GREEN, RED, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)  ns_ew("legal_ns_yellow", YELLOW, RED, 0, 0, 0, 0);
    ns_ew("legal_all_red", RED, RED, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  ns_ew("legal_ew_green", RED, GREEN, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  ns_ew("legal_ew_yellow_min", RED, YELLOW, 0, 0, 0, 0);
    ns_ew("legal_ew_red", RED, RED, 0, 0, 0, 0);

    // Conflict, persisting while both directions are non-RED.
    do_reset(2);
    ns_ew("conf_setup", GREEN, RED, 0, 0, 0, 0);
    ns_ew("conflict", GREEN, GREEN, 1, 0, 0, 0);
    ns_ew("conflict_hold", GREEN, GREEN, 1, 0, 0, 0);
    ns_ew("conflict_ew_yellow", GREEN, YELLOW, 1, 0, 0, 0);

    // GREEN->RED on both N/S heads: one seq pulse, sticky then holds.
    do_reset(2);
    ns_ew("seq_setup", GREEN, RED, 0, 0, 0, 0);
    ns_ew("seq_green_to_red", RED, RED, 0, 0, 1, 0);
    ns_ew("seq_hold_red", RED, RED, 0, 0, 0, 0);
    ns_ew("seq_sticky_holds", RED, GREEN, 0, 0, 0, 0);

    // YELLOW too short, too long (one pulse), and exactly YELLOW_MAX.
    do_reset(2);
    ns_ew("short_setup", GREEN, RED, 0, 0, 0, 0);
    ns_ew("short_y1", YELLOW, RED, 0, 0, 0, 0);
    ns_ew("short_y2", YELLOW, RED, 0, 0, 0, 0);
    ns_ew("short_exit", RED, RED, 0, 0, 0, 1);
    ns_ew("short_after", RED, RED, 0, 0, 0, 0);
    ns_ew("long_green", GREEN, RED, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) ns_ew("long_y_ok", YELLOW, RED, 0, 0, 0, 0);
    ns_ew("long_y6", YELLOW, RED, 0, 0, 0, 1);
    ns_ew("long_y7_no_repeat", YELLOW, RED, 0, 0, 0, 0);
    ns_ew("long_exit", RED, RED, 0, 0, 0, 0);
    ns_ew("max_green", GREEN, RED, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) ns_ew("max_y", YELLOW, RED, 0, 0, 0, 0);
    ns_ew("max_exit", RED, RED, 0, 0, 0, 0);

    // Pair mismatch and conflict together.
    do_reset(2);
    ns_ew("pc_setup", RED, RED, 0, 0, 0, 0);
    apply("pair_conflict", 1'b0, GREEN, RED, GREEN, RED, 1, 1, 0, 0);
    apply("pair_conflict_hold", 1'b0, GREEN, RED, GREEN, RED, 1, 1, 0, 0);

    // Reset mid-YELLOW abandons the interval; first sample after reset is not checked.
    do_reset(2);
    ns_ew("mid_setup", GREEN, RED, 0, 0, 0, 0);
    ns_ew("mid_y1", YELLOW, RED, 0, 0, 0, 0);
    apply("rst_mid_yellow", 1'b1, YELLOW, YELLOW, RED, RED, 0, 0, 0, 0);
    ns_ew("post_rst_red", RED, RED, 0, 0, 0, 0);
    ns_ew("post_rst_red2", RED, RED, 0, 0, 0, 0);
    apply("rst_green", 1'b1, GREEN, GREEN, RED, RED, 0, 0, 0, 0);
    ns_ew("post_rst_no_seq", RED, RED, 0, 0, 0, 0);

    // 300 continuous pair-error cycles: count saturates at 255.
    do_reset(2);
    ns_ew("sat_setup", RED, RED, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) apply("sat_pair", 1'b0, GREEN, RED, RED, RED, 0, 1, 0, 0);
    do_reset(1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #5;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 SHALL have parameter YELLOW_MIN, default 3, meaning the minimum legal YELLOW duration in cycles.
REQ-002 SHALL have parameter YELLOW_MAX, default 8, meaning the maximum legal YELLOW duration in cycles (YELLOW_MAX >= YELLOW_MIN >= 1).
REQ-003 SHALL have parameter CNT_W, default 8, meaning the error counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 north, south, east, west  input  2 (traffic_light) each  observed signal heads.
REQ-007 err_conflict  output  1  registered pulse; a north/south head and an east/west head are both non-RED.
REQ-008 err_pair  output  1  registered pulse; north != south or east != west.
REQ-009 err_seq  output  1  registered pulse; an illegal transition occurred on any head.
REQ-010 err_yellow  output  1  registered pulse; a YELLOW interval was too short or too long.
REQ-011 err_sticky  output  1  set by any error pulse, cleared only by rst.
REQ-012 err_count  output  CNT_W  saturating count of error cycles (present only with LIGHT_MON_COUNT_EN).

Function
REQ-013 Inputs SHALL be sampled every cycle; each error output SHALL assert exactly one cycle after the offending sample (latency 1) and stay high only for as long as the condition persists.
REQ-014 Conflict: err_conflict SHALL assert if (north != RED or south != RED) and (east != RED or west != RED).
REQ-015 Legal transitions per head: GREEN->YELLOW, LEFT->YELLOW, GREEN->LEFT, YELLOW->RED, RED->GREEN, RED->LEFT, and X->X (hold); all others, e.g. GREEN->RED, YELLOW->GREEN, RED->YELLOW, SHALL assert err_seq.
REQ-016 Each head SHALL keep a yellow counter: it loads 1 on entry to YELLOW, increments while YELLOW holds, and saturates at YELLOW_MAX+1.
REQ-017 err_yellow SHALL assert when the counter reaches YELLOW_MAX+1 while the head is still YELLOW (over-long), checked once per interval.
REQ-018 err_yellow SHALL assert when the head leaves YELLOW with a count < YELLOW_MIN (too short).
REQ-019 When several errors occur in the same cycle, all corresponding flags SHALL assert together; there is no priority masking.
REQ-020 err_sticky SHALL be set on the cycle any err_* pulse is high and hold thereafter.
REQ-021 The first sample after reset SHALL establish the previous state only; no err_seq or err_yellow is raised for it. err_conflict and err_pair are checked from the first sample.

Reset
REQ-022 While rst is high, all error outputs, err_sticky and err_count SHALL be 0, the yellow counters SHALL be 0, and the previous-state valid bits SHALL be cleared.
REQ-023 rst asserted mid-YELLOW SHALL abandon the interval without flagging; checking resumes per REQ-021.

Configuration
REQ-024 Macro LIGHT_MON_COUNT_EN SHALL enable err_count, which increments by 1 on every cycle any err_* pulse is high and saturates at all-ones.
REQ-025 Without LIGHT_MON_COUNT_EN, the err_count port and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 The traffic_light enum (GREEN=0, YELLOW=1, RED=2, LEFT=3) SHALL live in the shared package traffic_pkg, together with a legal-transition function used by both the DUT and the checker.
REQ-027 The per-head previous state, yellow counter, err_seq and err_yellow logic SHALL be a sub-module light_tracker, instantiated four times; the top level ORs the tracker outputs and holds the conflict and pair logic.

Verification (YELLOW_MIN=3, YELLOW_MAX=5)
REQ-028 Legal cycle: N/S GREEN 10 cycles, YELLOW 4, RED; E/W RED then GREEN -> no error flag ever, err_sticky=0.
REQ-029 Conflict: north=GREEN and east=GREEN sampled at cycle t -> err_conflict=1 at t+1, err_sticky=1 from t+1.
REQ-030 Illegal transition: north GREEN->RED at t (south identical) -> err_seq=1 at t+1 only, err_pair=0.
REQ-031 Yellow too short: YELLOW for 2 cycles then RED -> err_yellow=1 one cycle after the first RED sample; YELLOW for 6 cycles -> err_yellow=1 one cycle after the 6th YELLOW sample, one pulse only.
REQ-032 Pair mismatch plus conflict in the same cycle: north=GREEN, south=RED, east=GREEN -> err_pair=1 and err_conflict=1 together; with LIGHT_MON_COUNT_EN, err_count increments by 1.
REQ-033 Reset mid-YELLOW after 1 cycle, then RED -> no err_yellow and no err_seq; with the macro, err_count saturates at 255 after 300 continuous error cycles.
